// File: rtl/fp_mul_iter.sv
// fp_mul_iter: multi-cycle IEEE-754 binary64 multiplier.
// Sequence per operation: UNPACK -> MUL -> NORM -> ROUND -> DONE, one state per clock.
// Subnormal inputs are flushed to zero, tiny results are flushed to zero, rounding is
// round-to-nearest-even, and every NaN result is the canonical qNaN.
// Only DWIDTH = 64 is supported.
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   valid        one-cycle request pulse; accepted when ready is high
//   ready        high in IDLE and DONE
//   a, b         binary64 operands, captured on the accepting edge
//   finish       one-cycle pulse, result valid (state DONE)
//   result       binary64 product, held until the next DONE
module fp_mul_iter #(
    parameter int unsigned DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    output logic              ready,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic              finish,
    output logic [DWIDTH-1:0] result
);

    localparam int unsigned EW   = 11;
    localparam int unsigned FW   = 52;
    localparam int unsigned MW   = FW + 1;
    localparam int unsigned PW   = 2 * MW;
    localparam int unsigned XW   = 13;
    localparam int unsigned EMAX = 2047;
    localparam int unsigned BIAS = 1023;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_MUL    = 3'd2;
    localparam logic [2:0] S_NORM   = 3'd3;
    localparam logic [2:0] S_ROUND  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Operand class of the pair, resolved once in UNPACK.
    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_ZERO = 2'd1;
    localparam logic [1:0] K_INF  = 2'd2;
    localparam logic [1:0] K_NAN  = 2'd3;

    logic [2:0]              state_q;
    logic [2:0]              state_d;
    logic                    accept_c;

    logic [DWIDTH-1:0]       a_q;
    logic [DWIDTH-1:0]       b_q;
    logic                    sign_q;
    logic [1:0]              kind_q;
    logic [EW-1:0]           exp_a_q;
    logic [EW-1:0]           exp_b_q;
    logic [MW-1:0]           mant_a_q;
    logic [MW-1:0]           mant_b_q;
    logic [PW-1:0]           prod_q;
    logic signed [XW-1:0]    exp_q;
    logic [FW-1:0]           frac_q;
    logic [2:0]              grs_q;

    logic [1:0]              kind_c;
    logic [FW-1:0]           frac_c;
    logic [2:0]              grs_c;
    logic                    inc_c;
    logic [FW:0]             mant_rnd_c;
    logic signed [XW-1:0]    exp_fin_c;
    logic [DWIDTH-1:0]       res_c;

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d  = S_UNPACK;
                    accept_c = 1'b1;
                end
            end
            S_UNPACK: state_d = S_MUL;
            S_MUL:    state_d = S_NORM;
            S_NORM:   state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE: begin
                if (valid) begin
                    state_d  = S_UNPACK;
                    accept_c = 1'b1;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // State register and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready   <= 1'b1;
            finish  <= 1'b0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            ready   <= (state_d == S_IDLE) || (state_d == S_DONE);
            finish  <= (state_d == S_DONE);
            if (state_q == S_ROUND) begin
                result <= res_c;
            end
        end
    end

    // Special-case classification; subnormals (exponent field 0) count as zero.
    always_comb begin
        logic a_max;
        logic b_max;
        logic a_nan;
        logic b_nan;
        logic a_inf;
        logic b_inf;
        logic a_zero;
        logic b_zero;
        a_max  = &a_q[FW +: EW];
        b_max  = &b_q[FW +: EW];
        a_nan  = a_max && (|a_q[FW-1:0]);
        b_nan  = b_max && (|b_q[FW-1:0]);
        a_inf  = a_max && !(|a_q[FW-1:0]);
        b_inf  = b_max && !(|b_q[FW-1:0]);
        a_zero = !(|a_q[FW +: EW]);
        b_zero = !(|b_q[FW +: EW]);
        kind_c = K_NONE;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            kind_c = K_NAN;
        end else if (a_inf || b_inf) begin
            kind_c = K_INF;
        end else if (a_zero || b_zero) begin
            kind_c = K_ZERO;
        end
    end

    // Normalisation: leading one sits at bit 105 or 104 of the product.
    always_comb begin
        frac_c = '0;
        grs_c  = '0;
        if (prod_q[PW-1]) begin
            frac_c = prod_q[PW-2 -: FW];
            grs_c  = {prod_q[PW-2-FW], prod_q[PW-3-FW], |prod_q[PW-4-FW:0]};
        end else begin
            frac_c = prod_q[PW-3 -: FW];
            grs_c  = {prod_q[PW-3-FW], prod_q[PW-4-FW], |prod_q[PW-5-FW:0]};
        end
    end

    // Round-to-nearest-even; a carry out of the fraction bumps the exponent
    // and leaves the fraction field at zero (mantissa 1.0).
    always_comb begin
        inc_c      = grs_q[2] && (grs_q[1] || grs_q[0] || frac_q[0]);
        mant_rnd_c = {1'b0, frac_q} + (FW+1)'(inc_c);
        exp_fin_c  = exp_q + $signed({{(XW-1){1'b0}}, mant_rnd_c[FW]});
        res_c      = {sign_q, exp_fin_c[EW-1:0], mant_rnd_c[FW-1:0]};
        case (kind_q)
            K_NAN:  res_c = {1'b0, EW'(EMAX), 1'b1, (FW-1)'(0)};
            K_INF:  res_c = {sign_q, EW'(EMAX), FW'(0)};
            K_ZERO: res_c = {sign_q, (DWIDTH-1)'(0)};
            default: begin
                if (exp_fin_c >= $signed(XW'(EMAX))) begin
                    res_c = {sign_q, EW'(EMAX), FW'(0)};
                end else if (exp_fin_c <= $signed(XW'(0))) begin
                    res_c = {sign_q, (DWIDTH-1)'(0)};
                end
            end
        endcase
    end

    // Datapath registers, one pipeline step per FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            kind_q   <= K_NONE;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            mant_a_q <= '0;
            mant_b_q <= '0;
            prod_q   <= '0;
            exp_q    <= '0;
            frac_q   <= '0;
            grs_q    <= '0;
        end else begin
            if (accept_c) begin
                a_q <= a;
                b_q <= b;
            end
            case (state_q)
                S_UNPACK: begin
                    sign_q   <= a_q[DWIDTH-1] ^ b_q[DWIDTH-1];
                    kind_q   <= kind_c;
                    exp_a_q  <= a_q[FW +: EW];
                    exp_b_q  <= b_q[FW +: EW];
                    mant_a_q <= {1'b1, a_q[FW-1:0]};
                    mant_b_q <= {1'b1, b_q[FW-1:0]};
                end
                S_MUL: begin
                    prod_q <= PW'(mant_a_q) * PW'(mant_b_q);
                    exp_q  <= $signed(XW'(exp_a_q)) + $signed(XW'(exp_b_q))
                              - $signed(XW'(BIAS));
                end
                S_NORM: begin
                    frac_q <= frac_c;
                    grs_q  <= grs_c;
                    exp_q  <= exp_q + $signed({{(XW-1){1'b0}}, prod_q[PW-1]});
                end
                default: ;
            endcase
        end
    end

endmodule
